// File: rtl/conv_fifo_pkg.sv
// rtl/conv_fifo_pkg.sv - shared defaults and width helpers for the convolution-core FIFO
package conv_fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 256;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the level can represent DEPTH itself.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - WIDTH x DEPTH simple dual-port RAM, sync write, registered read with enable
module fifo_mem_2p
    import conv_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register resets to zero and holds its value between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/conv_sync_fifo.sv
// rtl/conv_sync_fifo.sv - single-clock FIFO with level and thresholds; FIFO_ERR_FLAGS_EN adds overflow/underflow
module conv_sync_fifo
    import conv_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LVL_W  = lvl_w(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses the registered flags, so a write into an empty FIFO
    // is never visible to a read in the same cycle.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        level_next = level;
        if (wr_acc && !rd_acc) begin
            level_next = level + LVL_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_next = level - LVL_W'(1);
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Flags are registered from level_next so they line up with level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            level        <= level_next;
            rd_valid     <= rd_acc;
            full         <= (level_next == LVL_W'(DEPTH));
            empty        <= (level_next == '0);
            almost_full  <= (level_next >= LVL_W'(AF_THRESH));
            almost_empty <= (level_next <= LVL_W'(AE_THRESH));
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_sync_fifo.sv
// tb/tb_conv_sync_fifo.sv - directed self-checking bench for conv_sync_fifo (DEPTH=8, AF=6, AE=2)
module tb_conv_sync_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_word;

    conv_sync_fifo #(
        .WIDTH     (32),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic we, input logic [31:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_af"}, 32'(almost_full), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_underflow"}, 32'(underflow), 32'd0);
`endif
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b1;

        // 1. Fill with 0x11..0x88, then a rejected ninth write.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 32'h11 * (i + 1), 1'b0);
            chk($sformatf("fill_level_%0d", i), 32'(level), 32'(i + 1));
            chk($sformatf("fill_af_%0d", i), 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("fill_ae_%0d", i), 32'(almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            chk($sformatf("fill_full_%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        tick(1'b1, 32'hFF, 1'b0);
        chk("ovf_write_level", 32'(level), 32'd8);
        chk("ovf_write_full", 32'(full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_set", 32'(overflow), 32'd1);
`endif

        // 2. Drain in order.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk($sformatf("drain_valid_%0d", i), 32'(rd_valid), 32'd1);
            chk($sformatf("drain_data_%0d", i), rd_data, 32'h11 * (i + 1));
            chk($sformatf("drain_level_%0d", i), 32'(level), 32'(7 - i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);

        // 3. Read on empty is rejected and rd_data holds.
        tick(1'b0, 32'h0, 1'b1);
        chk("uf_valid", 32'(rd_valid), 32'd0);
        chk("uf_data_hold", rd_data, 32'h88);
        chk("uf_level", 32'(level), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow_set", 32'(underflow), 32'd1);
        tick(1'b0, 32'h0, 1'b0);
        chk("underflow_sticky", 32'(underflow), 32'd1);
`endif

        // 4. Hold level 4 with simultaneous read+write across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'hA0 + i, 1'b0);
            model_q.push_back(32'hA0 + i);
        end
        chk("steady_start_level", 32'(level), 32'd4);
        for (int i = 0; i < 20; i++) begin
            model_q.push_back(32'hB0 + i);
            tick(1'b1, 32'hB0 + i, 1'b1);
            exp_word = model_q.pop_front();
            chk($sformatf("steady_valid_%0d", i), 32'(rd_valid), 32'd1);
            chk($sformatf("steady_data_%0d", i), rd_data, exp_word);
            chk($sformatf("steady_level_%0d", i), 32'(level), 32'd4);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            exp_word = model_q.pop_front();
            chk($sformatf("steady_tail_%0d", i), rd_data, exp_word);
        end
        chk("steady_tail_empty", 32'(empty), 32'd1);

        // 5. Simultaneous access on empty, then on full.
        tick(1'b1, 32'hC0, 1'b1);
        chk("both_empty_level", 32'(level), 32'd1);
        chk("both_empty_valid", 32'(rd_valid), 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick(1'b1, 32'hC0 + i, 1'b0);
        end
        chk("refill_full", 32'(full), 32'd1);
        tick(1'b1, 32'hD0, 1'b1);
        chk("both_full_level", 32'(level), 32'd7);
        chk("both_full_valid", 32'(rd_valid), 32'd1);
        chk("both_full_data", rd_data, 32'hC0);
        chk("both_full_notfull", 32'(full), 32'd0);

        // 6. Thresholds on the way down, then reset mid-stream.
        tick(1'b0, 32'h0, 1'b1);
        chk("thr_l6_data", rd_data, 32'hC1);
        chk("thr_l6_af", 32'(almost_full), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        chk("thr_l5_af", 32'(almost_full), 32'd0);
        tick(1'b0, 32'h0, 1'b1);
        tick(1'b0, 32'h0, 1'b1);
        chk("thr_l3_level", 32'(level), 32'd3);
        chk("thr_l3_ae", 32'(almost_empty), 32'd0);
        tick(1'b0, 32'h0, 1'b1);
        chk("thr_l2_data", rd_data, 32'hC5);
        chk("thr_l2_ae", 32'(almost_empty), 32'd1);

        wr_en   = 1'b1;
        wr_data = 32'hEE;
        rd_en   = 1'b1;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("midrst");
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        tick(1'b0, 32'h0, 1'b1);
        chk("post_rst_read_valid", 32'(rd_valid), 32'd0);
        chk("post_rst_level", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
